// File: rtl/vscale_mem_arbiter_pkg.sv
// ============================================================================
// Module      : vscale_mem_arbiter_pkg
// Description : Shared constants for the vscale memory arbiter. Holds the
//               datapath widths, memory access size codes and the encoding
//               of the data-phase owner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vscale_mem_arbiter_pkg;

    localparam int XPR_LEN        = 32;
    localparam int MEM_TYPE_WIDTH = 3;

    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LB  = 3'd0;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LH  = 3'd1;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LW  = 3'd2;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LD  = 3'd3;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LBU = 3'd4;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LHU = 3'd5;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LWU = 3'd6;

    // Width of the streak counter; large enough for the maximum bound of 15.
    localparam int STREAK_WIDTH = 4;

    localparam int ARB_OWNER_WIDTH = 2;

    typedef enum logic [ARB_OWNER_WIDTH-1:0] {
        ARB_OWNER_NONE = 2'd0,
        ARB_OWNER_I    = 2'd1,
        ARB_OWNER_D    = 2'd2
    } arb_owner_e;

endpackage

`default_nettype wire

// File: rtl/vscale_arb_streak_ctr.sv
// ============================================================================
// Module      : vscale_arb_streak_ctr
// Description : Saturating up-counter with synchronous clear. Counts
//               consecutive data-side grants taken while a fetch waits.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               clr_i           - clear to zero (wins over inc_i)
//               inc_i           - increment, saturating at MAX_COUNT
//               count_o         - current count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vscale_arb_streak_ctr
    import vscale_mem_arbiter_pkg::*;
#(
    parameter int MAX_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr_i,
    input  logic                    inc_i,
    output logic [STREAK_WIDTH-1:0] count_o
);

    localparam logic [STREAK_WIDTH-1:0] C_MAX = STREAK_WIDTH'(MAX_COUNT);

    logic [STREAK_WIDTH-1:0] count_q;
    logic [STREAK_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != C_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/vscale_mem_arbiter.sv
// ============================================================================
// Module      : vscale_mem_arbiter
// Description : Shares one pipelined memory port between the fetch (imem)
//               and data (dmem) sides of the vscale core. Data side has
//               priority, bounded by MAX_D_STREAK consecutive grants while a
//               fetch is pending. The owner of the outstanding data phase is
//               tracked so responses, errors and store data are routed to
//               the right side.
// Ports       : clk, reset                     - clock, sync active-high reset
//               imem_req/addr                  - fetch request
//               imem_wait/rdata/badmem_e       - fetch response
//               dmem_en/wen/size/addr          - data request
//               dmem_wdata_delayed             - store data, one cycle late
//               dmem_wait/rdata/badmem_e       - data response
//               mem_en/wen/size/addr/wdata     - shared memory request
//               mem_rdata/wait/badmem_e        - shared memory response
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vscale_mem_arbiter
    import vscale_mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      imem_req,
    input  logic [XPR_LEN-1:0]        imem_addr,
    output logic                      imem_wait,
    output logic [XPR_LEN-1:0]        imem_rdata,
    output logic                      imem_badmem_e,
    input  logic                      dmem_en,
    input  logic                      dmem_wen,
    input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
    input  logic [XPR_LEN-1:0]        dmem_addr,
    input  logic [XPR_LEN-1:0]        dmem_wdata_delayed,
    output logic                      dmem_wait,
    output logic [XPR_LEN-1:0]        dmem_rdata,
    output logic                      dmem_badmem_e,
    output logic                      mem_en,
    output logic                      mem_wen,
    output logic [MEM_TYPE_WIDTH-1:0] mem_size,
    output logic [XPR_LEN-1:0]        mem_addr,
    output logic [XPR_LEN-1:0]        mem_wdata,
    input  logic [XPR_LEN-1:0]        mem_rdata,
    input  logic                      mem_wait,
    input  logic                      mem_badmem_e
);

    localparam logic [STREAK_WIDTH-1:0] C_STREAK_MAX = STREAK_WIDTH'(MAX_D_STREAK);

    arb_owner_e              owner_q;
    arb_owner_e              owner_d;
    logic [STREAK_WIDTH-1:0] streak_q;
    logic                    slot_open;
    logic                    grant_d;
    logic                    grant_i;
    logic                    streak_clr;
    logic                    streak_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= ARB_OWNER_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        slot_open  = 1'b0;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        owner_d    = owner_q;
        streak_clr = 1'b0;
        streak_inc = 1'b0;

        // A new address phase may overlap the last cycle of the current
        // data phase, i.e. whenever the memory is not stalling it.
        slot_open = (owner_q == ARB_OWNER_NONE) || !mem_wait;

        if (slot_open && !reset) begin
            grant_d = dmem_en && (!imem_req || (streak_q < C_STREAK_MAX));
            grant_i = imem_req && !grant_d;
        end

        if (slot_open) begin
            if (grant_d) begin
                owner_d = ARB_OWNER_D;
            end else if (grant_i) begin
                owner_d = ARB_OWNER_I;
            end else begin
                owner_d = ARB_OWNER_NONE;
            end
        end

        // The streak only measures how long a waiting fetch has been passed
        // over; a D grant with no fetch pending restarts it.
        streak_clr = grant_i || (grant_d && !imem_req);
        streak_inc = grant_d && imem_req;
    end

    vscale_arb_streak_ctr #(
        .MAX_COUNT (MAX_D_STREAK)
    ) u_streak_ctr (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (streak_clr),
        .inc_i   (streak_inc),
        .count_o (streak_q)
    );

    // Address phase mux; idle bus is driven to zero.
    always_comb begin
        mem_en   = grant_d || grant_i;
        mem_wen  = 1'b0;
        mem_size = '0;
        mem_addr = '0;
        if (grant_d) begin
            mem_wen  = dmem_wen;
            mem_size = dmem_size;
            mem_addr = dmem_addr;
        end else if (grant_i) begin
            mem_size = MEM_TYPE_LW;
            mem_addr = imem_addr;
        end
    end

    assign imem_wait = ((owner_q == ARB_OWNER_I) && mem_wait) || (imem_req && !grant_i);
    assign dmem_wait = ((owner_q == ARB_OWNER_D) && mem_wait) || (dmem_en && !grant_d);

    assign imem_rdata    = mem_rdata;
    assign dmem_rdata    = mem_rdata;
    assign imem_badmem_e = mem_badmem_e && (owner_q == ARB_OWNER_I);
    assign dmem_badmem_e = mem_badmem_e && (owner_q == ARB_OWNER_D);

    assign mem_wdata = (owner_q == ARB_OWNER_D) ? dmem_wdata_delayed : '0;

endmodule

`default_nettype wire

// File: tb/tb_vscale_mem_arbiter.sv
// ============================================================================
// Module      : tb_vscale_mem_arbiter
// Description : Self-checking bench for vscale_mem_arbiter. A transaction
//               level reference model predicts every output each cycle;
//               directed scenarios add explicit checks on top.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vscale_mem_arbiter;
    import vscale_mem_arbiter_pkg::*;

    localparam int MAXS = 4;

    logic                      clk;
    logic                      reset;
    logic                      imem_req;
    logic [XPR_LEN-1:0]        imem_addr;
    logic                      imem_wait;
    logic [XPR_LEN-1:0]        imem_rdata;
    logic                      imem_badmem_e;
    logic                      dmem_en;
    logic                      dmem_wen;
    logic [MEM_TYPE_WIDTH-1:0] dmem_size;
    logic [XPR_LEN-1:0]        dmem_addr;
    logic [XPR_LEN-1:0]        dmem_wdata_delayed;
    logic                      dmem_wait;
    logic [XPR_LEN-1:0]        dmem_rdata;
    logic                      dmem_badmem_e;
    logic                      mem_en;
    logic                      mem_wen;
    logic [MEM_TYPE_WIDTH-1:0] mem_size;
    logic [XPR_LEN-1:0]        mem_addr;
    logic [XPR_LEN-1:0]        mem_wdata;
    logic [XPR_LEN-1:0]        mem_rdata;
    logic                      mem_wait;
    logic                      mem_badmem_e;

    vscale_mem_arbiter #(.MAX_D_STREAK(MAXS)) dut (
        .clk                (clk),
        .reset              (reset),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_wait          (imem_wait),
        .imem_rdata         (imem_rdata),
        .imem_badmem_e      (imem_badmem_e),
        .dmem_en            (dmem_en),
        .dmem_wen           (dmem_wen),
        .dmem_size          (dmem_size),
        .dmem_addr          (dmem_addr),
        .dmem_wdata_delayed (dmem_wdata_delayed),
        .dmem_wait          (dmem_wait),
        .dmem_rdata         (dmem_rdata),
        .dmem_badmem_e      (dmem_badmem_e),
        .mem_en             (mem_en),
        .mem_wen            (mem_wen),
        .mem_size           (mem_size),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_wait           (mem_wait),
        .mem_badmem_e       (mem_badmem_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: who owns the outstanding data phase (0 none, 1 fetch,
    // 2 data) and how many D grants a waiting fetch has been passed over.
    int m_owner  = 0;
    int m_streak = 0;

    // Snapshot of DUT outputs taken at the last checked cycle.
    logic        o_mem_en, o_mem_wen, o_imem_wait, o_dmem_wait;
    logic        o_imem_bad, o_dmem_bad;
    logic [31:0] o_mem_addr, o_mem_wdata, o_imem_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check every output mid-cycle against the model, then let
    // the model take the same clock edge as the DUT.
    task automatic step();
        bit          slot, gd, gi;
        logic [31:0] e_addr;
        logic [2:0]  e_size;
        @(negedge clk);
        slot = (m_owner == 0) || !mem_wait;
        gd   = !reset && slot && dmem_en && (!imem_req || (m_streak < MAXS));
        gi   = !reset && slot && imem_req && !gd;
        e_addr = gd ? dmem_addr : (gi ? imem_addr : 32'h0);
        e_size = gd ? dmem_size : (gi ? MEM_TYPE_LW : 3'd0);
        chk("mem_en",        {31'b0, mem_en},        {31'b0, gd | gi});
        chk("mem_wen",       {31'b0, mem_wen},       {31'b0, gd & dmem_wen});
        chk("mem_size",      {29'b0, mem_size},      {29'b0, e_size});
        chk("mem_addr",      mem_addr,               e_addr);
        chk("mem_wdata",     mem_wdata,              (m_owner == 2) ? dmem_wdata_delayed : 32'h0);
        chk("imem_wait",     {31'b0, imem_wait},
            {31'b0, ((m_owner == 1) && mem_wait) || (imem_req && !gi)});
        chk("dmem_wait",     {31'b0, dmem_wait},
            {31'b0, ((m_owner == 2) && mem_wait) || (dmem_en && !gd)});
        chk("imem_rdata",    imem_rdata,             mem_rdata);
        chk("dmem_rdata",    dmem_rdata,             mem_rdata);
        chk("imem_badmem_e", {31'b0, imem_badmem_e}, {31'b0, mem_badmem_e && (m_owner == 1)});
        chk("dmem_badmem_e", {31'b0, dmem_badmem_e}, {31'b0, mem_badmem_e && (m_owner == 2)});
        o_mem_en     = mem_en;
        o_mem_wen    = mem_wen;
        o_mem_addr   = mem_addr;
        o_mem_wdata  = mem_wdata;
        o_imem_wait  = imem_wait;
        o_dmem_wait  = dmem_wait;
        o_imem_bad   = imem_badmem_e;
        o_dmem_bad   = dmem_badmem_e;
        o_imem_rdata = imem_rdata;
        @(posedge clk);
        if (reset) begin
            m_owner  = 0;
            m_streak = 0;
        end else begin
            if (slot) m_owner = gd ? 2 : (gi ? 1 : 0);
            if (gi) m_streak = 0;
            else if (gd) m_streak = imem_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        imem_req = 0; imem_addr = 0;
        dmem_en = 0; dmem_wen = 0; dmem_size = MEM_TYPE_LW; dmem_addr = 0;
        dmem_wdata_delayed = 0;
        mem_rdata = 0; mem_wait = 0; mem_badmem_e = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        step();
        // Outputs during reset with no request.
        chk("reset_mem_en",    {31'b0, o_mem_en},    32'h0);
        chk("reset_dmem_wait", {31'b0, o_dmem_wait}, 32'h0);
        step();
        reset = 0;

        // Lone fetch.
        imem_req = 1; imem_addr = 32'h200;
        step();
        chk("fetch_en",   {31'b0, o_mem_en}, 32'h1);
        chk("fetch_addr", o_mem_addr,        32'h200);
        imem_req = 0; mem_rdata = 32'h13;
        step();
        chk("fetch_rdata", o_imem_rdata,         32'h13);
        chk("fetch_wait",  {31'b0, o_imem_wait}, 32'h0);
        mem_rdata = 0;

        // Contention: D,D,D,D,I repeating.
        imem_req = 1; imem_addr = 32'h400; dmem_en = 1; dmem_addr = 32'h800;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("contend_addr", o_mem_addr, ((k % 5) != 4) ? 32'h800 : 32'h400);
            chk("contend_iwait", {31'b0, o_imem_wait}, ((k % 5) != 4) ? 32'h1 : 32'h0);
        end
        idle_inputs();
        step();

        // Store data lands only in the data phase.
        dmem_en = 1; dmem_wen = 1; dmem_addr = 32'h1000; dmem_size = MEM_TYPE_LW;
        step();
        chk("store_wen", {31'b0, o_mem_wen}, 32'h1);
        dmem_en = 0; dmem_wen = 0; dmem_wdata_delayed = 32'hDEADBEEF;
        step();
        chk("store_wdata", o_mem_wdata, 32'hDEADBEEF);
        step();
        chk("store_wdata_after", o_mem_wdata, 32'h0);
        dmem_wdata_delayed = 0;

        // Wait stretch on a load.
        dmem_en = 1; dmem_addr = 32'h2000;
        step();
        dmem_en = 0; imem_req = 1; imem_addr = 32'h300; mem_wait = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_dwait", {31'b0, o_dmem_wait}, 32'h1);
            chk("stall_noen",  {31'b0, o_mem_en},    32'h0);
        end
        mem_wait = 0;
        step();
        chk("stall_release_addr", o_mem_addr, 32'h300);

        // Error routing to the fetch side.
        imem_req = 0; mem_badmem_e = 1;
        step();
        chk("err_i", {31'b0, o_imem_bad}, 32'h1);
        chk("err_d", {31'b0, o_dmem_bad}, 32'h0);
        mem_badmem_e = 0;

        // Reset mid data phase.
        dmem_en = 1; dmem_addr = 32'h3000;
        step();
        dmem_en = 0; mem_wait = 1;
        step();
        reset = 1;
        step();
        reset = 0;
        step();
        chk("rst_dwait", {31'b0, o_dmem_wait}, 32'h0);
        mem_wait = 0;
        imem_req = 1; imem_addr = 32'h500; dmem_en = 1; dmem_addr = 32'h900;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rst_contend_addr", o_mem_addr, (k != 4) ? 32'h900 : 32'h500);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            reset              = ($urandom_range(49) == 0);
            imem_req           = $urandom_range(1);
            imem_addr          = $urandom;
            dmem_en            = $urandom_range(1);
            dmem_wen           = $urandom_range(1);
            dmem_size          = 3'($urandom_range(6));
            dmem_addr          = $urandom;
            dmem_wdata_delayed = $urandom;
            mem_rdata          = $urandom;
            mem_wait           = ($urandom_range(2) == 0);
            mem_badmem_e       = ($urandom_range(3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vscale_mem_arbiter.md
# vscale_mem_arbiter

Shares a single pipelined memory port between the instruction-fetch and data-access sides of the vscale core. It sits between `vscale_pipeline` (imem/dmem ports) and the external memory (single-ported SRAM or bus bridge). It arbitrates address phases with data-side priority plus an anti-starvation bound, tracks the owner of the outstanding data phase, and returns data, error and wait signalling to the correct requester.

## Interface
- `MAX_D_STREAK`, default 4: maximum consecutive dmem grants while an imem request is pending; range 1–15.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `imem_req` in 1: fetch request valid.
- `imem_addr` in `XPR_LEN`: fetch address.
- `imem_wait` out 1: fetch side must hold its request, or its response is not ready.
- `imem_rdata` out `XPR_LEN`: fetch data.
- `imem_badmem_e` out 1: fetch access error.
- `dmem_en`, `dmem_wen` in 1: data request valid and write enable.
- `dmem_size` in `MEM_TYPE_WIDTH`: access size.
- `dmem_addr` in `XPR_LEN`: data address.
- `dmem_wdata_delayed` in `XPR_LEN`: store data, presented one cycle after its address.
- `dmem_wait` out 1, `dmem_rdata` out `XPR_LEN`, `dmem_badmem_e` out 1: data-side equivalents of the fetch outputs.
- `mem_en`, `mem_wen` out 1; `mem_size` out `MEM_TYPE_WIDTH`; `mem_addr` out `XPR_LEN`: shared address phase.
- `mem_wdata` out `XPR_LEN`: write data, driven in the data phase.
- `mem_rdata` in `XPR_LEN`, `mem_wait` in 1, `mem_badmem_e` in 1: shared data phase.

## Operation
- Each memory transaction has two phases. The address phase occupies cycle N. The data phase occupies cycle N+1 and is extended while `mem_wait`=1. Phases overlap: the next address phase may issue in the final cycle of the current data phase.
- The owner register holds the data-phase owner, one of NONE, I or D.
- The issue slot is open when owner==NONE or `mem_wait`=0.
- Grant rule, evaluated only when the issue slot is open:
  - grant_d = `dmem_en` & (~`imem_req` | streak<`MAX_D_STREAK`).
  - grant_i = `imem_req` & ~grant_d.
  - At most one grant is active per cycle. No grants are issued while `reset`=1.
- The address mux drives `mem_*` from the granted requester. `mem_en`=0 when there is no grant. `mem_wen` is forced to 0 on an I grant.
- Owner next state:
  - Issue slot open: owner becomes D on grant_d, I on grant_i, NONE on no grant.
  - Issue slot closed: owner holds.
- Streak counter:
  - grant_i: clear.
  - grant_d & `imem_req`: increment, saturating.
  - grant_d & ~`imem_req`: clear.
  - Otherwise: hold.
- `imem_wait` = (owner==I & `mem_wait`) | (`imem_req` & ~grant_i). `dmem_wait` is symmetric, using owner==D, `dmem_en` and grant_d.
- Read data:
  - `imem_rdata` = `dmem_rdata` = `mem_rdata`, unconditionally.
  - `imem_badmem_e` = `mem_badmem_e` & owner==I. `dmem_badmem_e` uses owner==D.
- Write data: `mem_wdata` = `dmem_wdata_delayed` when owner==D, otherwise 0.
- Boundary conditions:
  - Simultaneous requests: D wins unless the streak has saturated.
  - `mem_wait` held: no new issue; both waits are high for any pending request.
  - Reset mid-transaction: owner becomes NONE and streak becomes 0. The outstanding data phase is abandoned and its response is ignored.

## Timing
- Reset values: owner=NONE, streak=0. All outputs are therefore 0 during and after reset until a request arrives (`mem_en`=0, waits=0, badmem=0, `mem_wdata`=0). `*_rdata` follow `mem_rdata`.
- Latency: request at cycle N with no contention gives `mem_en`=1 at N and data at N+1. The arbiter adds zero cycles.
- All grant, mux and wait paths are combinational from registered owner/streak and the current inputs. Only owner and streak are flopped.
- Back-to-back throughput: one transaction per cycle when `mem_wait`=0.
- Worst-case fetch delay under continuous stores is `MAX_D_STREAK` issue slots.

## Structure
- Add owner encodings (`ARB_OWNER_NONE`/`I`/`D`, `ARB_OWNER_WIDTH`=2) to a shared `vscale_arbiter_constants.vh`.
- Reuse `XPR_LEN`, `MEM_TYPE_WIDTH` and the `MEM_TYPE_*` codes from the existing headers.
- One natural sub-module: `vscale_arb_streak_ctr`, the saturating counter with clear/increment controls. Everything else stays flat.

## Test plan
- Lone fetch: `imem_req`=1, addr 0x200, `mem_rdata`=0x13 at N+1 → `mem_en`=1 and `mem_addr`=0x200 at N; `imem_rdata`=0x13 and `imem_wait`=0 at N+1.
- Contention: both requests every cycle with `MAX_D_STREAK`=4 → grant pattern D,D,D,D,I repeating; `imem_wait`=1 on the D cycles.
- Store data: SW to addr 0x1000, `dmem_wdata_delayed`=0xDEADBEEF at N+1 → `mem_wen`=1 at N; `mem_wdata`=0xDEADBEEF at N+1 only; `mem_wdata`=0 otherwise.
- Wait stretch: D load issued, `mem_wait`=1 for 3 cycles → `dmem_wait`=1 for 3 cycles; no `mem_en` during the stall; the next address issues in the cycle `mem_wait` falls.
- Error routing: I fetch with `mem_badmem_e`=1 in its data phase → `imem_badmem_e`=1 and `dmem_badmem_e`=0.
- Reset mid-operation: assert `reset` during a stretched D data phase → next cycle owner=NONE; `dmem_wait`=0 with no request; streak=0, so the next contention restarts with 4 D grants.
